async_fifo_wr_arb: RTL and testbench

Write-side arbiter that shares the single write port of an asynchronous FIFO among NREQ requesters in the write clock domain. It grants the port round-robin, holds a grant for bursts of up to MAX_BURST beats, and drives the FIFO's write increment and write data. The FIFO's write-side full flag, derived from the synchronized read pointer, stalls transfers. It sits between the producer clients and the FIFO write-control logic.

---
 rtl/async_fifo_wr_arb_if.sv | 27 ++
 rtl/async_fifo_wr_arb.sv | 102 ++++++++++
 tb/tb_async_fifo_wr_arb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/async_fifo_wr_arb_if.sv
// Producer-side bus of the async FIFO write arbiter: requests, per-requester
// data, FIFO full flag, and the arbiter's acknowledge, write strobe and grant status.
interface async_fifo_wr_arb_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] data;
    logic                  wfull;
    logic [NREQ-1:0]       ack;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  grant_valid;
    logic [ID_W-1:0]       grant_id;

    modport master (
        output req, data, wfull,
        input  ack, winc, wdata, grant_valid, grant_id
    );

    modport slave (
        input  req, data, wfull,
        output ack, winc, wdata, grant_valid, grant_id
    );
endinterface

// File: rtl/async_fifo_wr_arb.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ write-domain
// requesters, with bursts capped at MAX_BURST beats and stalls on wfull.
module async_fifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    async_fifo_wr_arb_if.slave   bus
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   grant_id, grant_id_nxt;
    logic [ID_W-1:0]   last_id, last_id_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;

    logic              beat;
    logic              found;
    logic [ID_W-1:0]   winner;

    // Search starts just after the last holder, so while a grant is held the
    // holder itself is the lowest priority: it wins only when alone.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_id) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign beat = (state == GRANT) && bus.req[grant_id] && !bus.wfull;

    always_comb begin
        state_nxt    = state;
        grant_id_nxt = grant_id;
        last_id_nxt  = last_id;
        beat_cnt_nxt = beat_cnt;
        bus.ack      = '0;
        bus.winc     = 1'b0;
        bus.wdata    = '0;

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    grant_id_nxt = winner;
                    last_id_nxt  = winner;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                bus.wdata = bus.data[int'(grant_id)*DSIZE +: DSIZE];
                if (beat) begin
                    bus.winc          = 1'b1;
                    bus.ack[grant_id] = 1'b1;
                end
                if (!bus.req[grant_id] ||
                    (beat && beat_cnt == CNT_W'(MAX_BURST - 1))) begin
                    if (found) begin
                        grant_id_nxt = winner;
                        last_id_nxt  = winner;
                        beat_cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (beat) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            last_id  <= ID_W'(NREQ - 1);
            beat_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state    <= state_nxt;
            grant_id <= grant_id_nxt;
            last_id  <= last_id_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign bus.grant_valid = (state == GRANT);
    assign bus.grant_id    = grant_id;
endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Directed bench for async_fifo_wr_arb: a vector table for bursts and
// round-robin, then hand-written stall, early-release, fairness and reset cases.
module tb_async_fifo_wr_arb;
    localparam int NREQ = 4, DSIZE = 8, MAX_BURST = 4;

    logic wclk;
    logic wrst_n;
    int   n_vec = 0;
    int   n_err = 0;

    async_fifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

    async_fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    typedef struct packed {
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] data;
        logic        wfull;
        logic [3:0]  ack;
        logic        winc;
        logic [7:0]  wdata;
        logic        gv;
        logic [1:0]  gid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [3:0] rq, logic [31:0] d, logic wf,
                                logic [3:0] a, logic w, logic [7:0] wd,
                                logic gv, logic [1:0] gid);
        vec_t v;
        v = '{rst_n: r, req: rq, data: d, wfull: wf, ack: a, winc: w,
              wdata: wd, gv: gv, gid: gid};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] rq, input logic [31:0] d, input logic wf);
        @(negedge wclk);
        bus.req   = rq;
        bus.data  = d;
        bus.wfull = wf;
        #1;
    endtask

    task automatic do_reset();
        @(negedge wclk);
        wrst_n   = 1'b0;
        bus.req  = '0;
        bus.data = '0;
        bus.wfull = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] a, input logic w,
                              input logic gv, input logic [1:0] gid);
        check({tag, " ack"},  32'(bus.ack), 32'(a));
        check({tag, " winc"}, 32'(bus.winc), 32'(w));
        check({tag, " gv"},   32'(bus.grant_valid), 32'(gv));
        if (gv) check({tag, " gid"}, 32'(bus.grant_id), 32'(gid));
    endtask

    localparam logic [31:0] D = 32'hD3C2_B1A0;

    initial begin
        int beats;

        wrst_n    = 1'b0;
        bus.req   = '0;
        bus.data  = '0;
        bus.wfull = 1'b0;

        // Single requester: 4-beat burst, seamless re-grant to itself, then drop.
        vecs.push_back(mk(0, 4'h0, 32'h0,  0, 4'h0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 4'h1, 32'hA0, 0, 4'h0, 0, 8'h00, 0, 0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1, 4'h1, 32'hA0 + 32'(i), 0, 4'h1, 1, 8'hA0 + 8'(i), 1, 0));
        vecs.push_back(mk(1, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 0));
        // Round robin 0 <-> 2 with burst limit and no gap cycles.
        vecs.push_back(mk(0, 4'h0, D, 0, 4'h0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 4'h5, D, 0, 4'h0, 0, 8'h00, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 4'h5, D, 0, 4'h1, 1, 8'hA0, 1, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 4'h5, D, 0, 4'h4, 1, 8'hC2, 1, 2));
        vecs.push_back(mk(1, 4'h5, D, 0, 4'h1, 1, 8'hA0, 1, 0));
        vecs.push_back(mk(1, 4'h0, D, 0, 4'h0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 4'h0, D, 0, 4'h0, 0, 8'h00, 0, 0));

        foreach (vecs[i]) begin
            @(negedge wclk);
            wrst_n    = vecs[i].rst_n;
            bus.req   = vecs[i].req;
            bus.data  = vecs[i].data;
            bus.wfull = vecs[i].wfull;
            #1;
            expect_out($sformatf("vec%0d", i), vecs[i].ack, vecs[i].winc,
                       vecs[i].gv, vecs[i].gid);
            if (vecs[i].winc || !vecs[i].gv)
                check($sformatf("vec%0d wdata", i), 32'(bus.wdata), 32'(vecs[i].wdata));
        end

        // Full stall after beat 2 of requester 1; exactly 2 more beats follow.
        do_reset();
        cyc(4'h6, D, 0); expect_out("stall idle", 4'h0, 0, 0, 0);
        cyc(4'h6, D, 0); expect_out("stall b1", 4'h2, 1, 1, 1);
        check("stall b1 wdata", 32'(bus.wdata), 32'hB1);
        cyc(4'h6, D, 0); expect_out("stall b2", 4'h2, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'h6, D, 1); expect_out($sformatf("stall full%0d", i), 4'h0, 0, 1, 1);
        end
        cyc(4'h6, D, 0); expect_out("stall b3", 4'h2, 1, 1, 1);
        cyc(4'h6, D, 0); expect_out("stall b4", 4'h2, 1, 1, 1);
        cyc(4'h6, D, 0); expect_out("stall handover", 4'h4, 1, 1, 2);
        check("stall handover wdata", 32'(bus.wdata), 32'hC2);

        // Early release: requester 3 drops after one beat, grant wraps to 0.
        do_reset();
        cyc(4'h8, D, 0); expect_out("early idle", 4'h0, 0, 0, 0);
        cyc(4'h8, D, 0); expect_out("early b3", 4'h8, 1, 1, 3);
        check("early b3 wdata", 32'(bus.wdata), 32'hD3);
        cyc(4'h1, D, 0); expect_out("early gap", 4'h0, 0, 1, 3);
        cyc(4'h1, D, 0); expect_out("early b0", 4'h1, 1, 1, 0);

        // Fairness: all four requesting for 40 cycles.
        do_reset();
        beats = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(4'hF, D, 0);
            if (bus.winc) begin
                check($sformatf("fair beat%0d gid", beats), 32'(bus.grant_id), 32'((beats / 4) % 4));
                check($sformatf("fair beat%0d ack", beats), 32'(bus.ack), 32'(1) << ((beats / 4) % 4));
                beats++;
            end
        end
        check("fair total winc", 32'(beats), 32'd39);

        // Reset mid-burst clears outputs immediately; requester 0 wins afterwards.
        do_reset();
        cyc(4'h2, D, 0); expect_out("rst idle", 4'h0, 0, 0, 0);
        cyc(4'h2, D, 0); expect_out("rst b1", 4'h2, 1, 1, 1);
        cyc(4'h2, D, 0); expect_out("rst b2", 4'h2, 1, 1, 1);
        wrst_n = 1'b0;
        #1;
        expect_out("rst asserted", 4'h0, 0, 0, 0);
        check("rst asserted wdata", 32'(bus.wdata), 32'h0);
        @(negedge wclk);
        wrst_n  = 1'b1;
        bus.req = 4'h3;
        #1;
        expect_out("rst released", 4'h0, 0, 0, 0);
        cyc(4'h3, D, 0); expect_out("rst regrant", 4'h1, 1, 1, 0);
        check("rst regrant wdata", 32'(bus.wdata), 32'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
